pipe_fetch_decode: RTL and testbench



---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/pipe_fetch_decode_if.sv | 35 +++
 rtl/pipe_fetch_decode_hazard_scoreboard.sv | 59 +++++
 rtl/pipe_fetch_decode.sv | 120 ++++++++++++
 tb/tb_pipe_fetch_decode.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the ALU/memory pipeline: instruction layout, function
// encodings and the front-end state encoding.
package pipe_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 24;
    localparam int FUNC_W  = 4;
    localparam int REG_W   = 4;
    localparam int ADDR_W  = 8;

    typedef enum logic [FUNC_W-1:0] {
        FN_ADD = 4'b0000,
        FN_SUB = 4'b0001,
        FN_SHL = 4'b1011,
        FN_NOP = 4'b1100,
        FN_HLT = 4'b1111
    } func_e;

    // Field order fixes the bit positions: func[23:20] rd[19:16] rs1[15:12] rs2[11:8] addr[7:0]
    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_e;

    function automatic logic is_alu(input logic [FUNC_W-1:0] f);
        return f <= FN_SHL;
    endfunction

    function automatic instr_t bubble_instr();
        instr_t r;
        r      = '0;
        r.func = FN_NOP;
        return r;
    endfunction

endpackage

// File: rtl/pipe_fetch_decode_if.sv
// Bus between the fetch/decode front end and its environment: imem load port,
// start control, and the decoded-issue fields consumed by register read.
interface pipe_fetch_decode_if #(
    parameter int STALL_W = 16
);
    import pipe_pkg::*;

    logic                 imem_we;
    logic [PC_W-1:0]      imem_waddr;
    logic [INSTR_W-1:0]   imem_wdata;
    logic                 start;
    logic [PC_W-1:0]      start_pc;

    logic                 issue_valid;
    logic [FUNC_W-1:0]    func;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [REG_W-1:0]     rd;
    logic [ADDR_W-1:0]    addr;
    logic [PC_W-1:0]      pc;
    logic                 busy;
    logic                 halted;
    logic [STALL_W-1:0]   stall_cnt;

    modport master (
        output imem_we, imem_waddr, imem_wdata, start, start_pc,
        input  issue_valid, func, rs1, rs2, rd, addr, pc, busy, halted, stall_cnt
    );

    modport slave (
        input  imem_we, imem_waddr, imem_wdata, start, start_pc,
        output issue_valid, func, rs1, rs2, rd, addr, pc, busy, halted, stall_cnt
    );

endinterface

// File: rtl/pipe_fetch_decode_hazard_scoreboard.sv
// Shift register of destination registers still pending writeback; flags a
// RAW hazard when either source of the fetched word matches a valid entry.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int HAZ_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             push_valid,
    input  logic [REG_W-1:0] push_rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             hazard
);

    logic [HAZ_DEPTH-1:0] valid_q, valid_d;
    logic [REG_W-1:0]     rd_q [HAZ_DEPTH];
    logic [REG_W-1:0]     rd_d [HAZ_DEPTH];
    logic [HAZ_DEPTH-1:0] match;

    generate
        for (genvar gi = 0; gi < HAZ_DEPTH; gi++) begin : g_cmp
            assign match[gi] = valid_q[gi] && ((rd_q[gi] == rs1) || (rd_q[gi] == rs2));
        end
    endgenerate

    assign hazard = |match;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        if (clear) begin
            valid_d = '0;
        end else if (push) begin
            valid_d[0] = push_valid;
            rd_d[0]    = push_rd;
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                rd_d[i]    = rd_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: rtl/pipe_fetch_decode.sv
// Pipeline front end: instruction memory, PC, decode and bubble insertion for
// RAW hazards against instructions whose result is not yet written back.
module pipe_fetch_decode
    import pipe_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int HAZ_DEPTH  = 2,
    parameter int STALL_W    = 16
) (
    input logic                clk,
    input logic                rst,
    pipe_fetch_decode_if.slave bus
);

    logic [INSTR_W-1:0] imem_mem [IMEM_DEPTH];

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               issue_valid_q, issue_valid_d;
    instr_t             instr_q, instr_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    instr_t             fetch_w;
    logic               sb_clear, sb_push, sb_push_valid, hazard;

    // Write port is independent of state; a same-cycle write to pc leaves the fetch on the old word.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            imem_mem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    assign fetch_w = imem_mem[pc_q];

    hazard_scoreboard #(
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .clear      (sb_clear),
        .push       (sb_push),
        .push_valid (sb_push_valid),
        .push_rd    (fetch_w.rd),
        .rs1        (fetch_w.rs1),
        .rs2        (fetch_w.rs2),
        .hazard     (hazard)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        issue_valid_d = 1'b0;
        instr_d       = bubble_instr();
        stall_d       = stall_q;
        sb_clear      = 1'b0;
        sb_push       = 1'b0;
        sb_push_valid = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_d  = ST_RUN;
                    pc_d     = bus.start_pc;
                    sb_clear = 1'b1;
                    stall_d  = '0;
                end
            end
            ST_RUN: begin
                sb_push = 1'b1;
                if (fetch_w.func == FN_HLT) begin
                    state_d = ST_HALT;
                end else if (is_alu(fetch_w.func)) begin
                    if (hazard) begin
                        if (stall_q != '1) begin
                            stall_d = stall_q + 1'b1;
                        end
                    end else begin
                        issue_valid_d = 1'b1;
                        instr_d       = fetch_w;
                        pc_d          = pc_q + 1'b1;
                        sb_push_valid = 1'b1;
                    end
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            issue_valid_q <= 1'b0;
            instr_q       <= bubble_instr();
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            issue_valid_q <= issue_valid_d;
            instr_q       <= instr_d;
            stall_q       <= stall_d;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.func        = instr_q.func;
    assign bus.rs1         = instr_q.rs1;
    assign bus.rs2         = instr_q.rs2;
    assign bus.rd          = instr_q.rd;
    assign bus.addr        = instr_q.addr;
    assign bus.pc          = pc_q;
    assign bus.busy        = (state_q == ST_RUN);
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_fetch_decode.sv
// Self-checking bench for pipe_fetch_decode: cycle-level reference model plus
// directed programs with hand-computed issue traces.
module tb_pipe_fetch_decode;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_fetch_decode_if #(.STALL_W(16)) bus ();

    pipe_fetch_decode #(
        .IMEM_DEPTH (256),
        .HAZ_DEPTH  (2),
        .STALL_W    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0] m_imem [256];
    bit          m_run, m_halt;
    logic [7:0]  m_pc;
    int          m_stall;
    int          m_recent[$];
    logic        e_valid;
    logic [3:0]  e_func, e_rs1, e_rs2, e_rd;
    logic [7:0]  e_addr;

    task automatic model_step(input logic r, input logic st, input logic [7:0] spc,
                              input logic we, input logic [7:0] wa, input logic [23:0] wd);
        logic [23:0] w;
        int          slot;
        bit          haz;
        e_valid = 1'b0; e_func = 4'hC; e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_addr = '0;
        if (r) begin
            m_run = 0; m_halt = 0; m_pc = '0; m_stall = 0; m_recent = {-1, -1};
        end else if (!m_run) begin
            if (st) begin
                m_run = 1; m_halt = 0; m_pc = spc; m_stall = 0; m_recent = {-1, -1};
            end
        end else begin
            w    = m_imem[m_pc];
            slot = -1;
            if (w[23:20] == 4'hF) begin
                m_run  = 0;
                m_halt = 1;
            end else if (w[23:20] < 4'hC) begin
                haz = 0;
                foreach (m_recent[k]) begin
                    if (m_recent[k] == int'(w[15:12]) || m_recent[k] == int'(w[11:8])) haz = 1;
                end
                if (haz) begin
                    if (m_stall < 65535) m_stall++;
                end else begin
                    e_valid = 1'b1;
                    {e_func, e_rd, e_rs1, e_rs2, e_addr} = w;
                    m_pc++;
                    slot = int'(w[19:16]);
                end
            end else begin
                m_pc++;
            end
            m_recent.push_front(slot);
            void'(m_recent.pop_back());
        end
        if (we) m_imem[wa] = wd;
    endtask

    initial begin
        m_recent = {-1, -1};
        forever begin
            @(posedge clk);
            model_step(rst, bus.start, bus.start_pc, bus.imem_we, bus.imem_waddr, bus.imem_wdata);
            #1;
            check("issue_valid", bus.issue_valid, e_valid);
            check("func",        bus.func,        e_func);
            check("rs1",         bus.rs1,         e_rs1);
            check("rs2",         bus.rs2,         e_rs2);
            check("rd",          bus.rd,          e_rd);
            check("addr",        bus.addr,        e_addr);
            check("pc",          bus.pc,          m_pc);
            check("busy",        bus.busy,        m_run);
            check("halted",      bus.halted,      m_halt);
            check("stall_cnt",   bus.stall_cnt,   m_stall);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [8:0] trace[$];
    logic [8:0] exp_q[$];

    task automatic load(input logic [7:0] a, input logic [23:0] w);
        bus.imem_we = 1'b1; bus.imem_waddr = a; bus.imem_wdata = w;
        @(negedge clk);
        bus.imem_we = 1'b0;
    endtask

    task automatic go(input logic [7:0] p);
        bus.start = 1'b1; bus.start_pc = p;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_trace(input int max_cycles);
        trace.delete();
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            trace.push_back({bus.issue_valid, bus.func, bus.rd});
            if (bus.issue_valid)
                $display("issue t=%0t func=%0h rd=%0h rs1=%0h rs2=%0h addr=%0h stalls=%0d",
                         $time, bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr, bus.stall_cnt);
            if (bus.halted) return;
        end
        check("halt_timeout", bus.halted, 1'b1);
    endtask

    task automatic check_trace(input string name, input logic [8:0] exp[$]);
        check({name, "_len"}, trace.size(), exp.size());
        for (int i = 0; i < exp.size() && i < trace.size(); i++)
            check(name, trace[i], exp[i]);
    endtask

    initial begin
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
        bus.start = 1'b0; bus.start_pc = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_issue_valid", bus.issue_valid, 1'b0);
        check("rst_func",        bus.func,        4'hC);
        check("rst_pc",          bus.pc,          8'd0);
        check("rst_busy",        bus.busy,        1'b0);
        check("rst_halted",      bus.halted,      1'b0);
        check("rst_stall",       bus.stall_cnt,   16'd0);

        // ADD, SUB, HLT: straight-line issue
        load(8'd0, 24'h031200); load(8'd1, 24'h145600); load(8'd2, 24'hF00000);
        go(8'd0);
        run_trace(20);
        check_trace("t1_trace", {9'h103, 9'h114, 9'h0C0});
        check("t1_pc", bus.pc, 8'd2);
        check("t1_stall", bus.stall_cnt, 16'd0);

        // ADD R3 then OR using R3: two bubbles
        load(8'd1, 24'h653400);
        go(8'd0);
        run_trace(20);
        check_trace("t2_trace", {9'h103, 9'h0C0, 9'h0C0, 9'h165, 9'h0C0});
        check("t2_stall", bus.stall_cnt, 16'd2);
        check("t2_pc", bus.pc, 8'd2);

        // ADD R3, XOR, AND using R3: one bubble
        load(8'd1, 24'h478900); load(8'd2, 24'h263100); load(8'd3, 24'hF00000);
        go(8'd0);
        run_trace(20);
        check_trace("t3_trace", {9'h103, 9'h147, 9'h0C0, 9'h126, 9'h0C0});
        check("t3_stall", bus.stall_cnt, 16'd1);
        check("t3_pc", bus.pc, 8'd3);

        // pc wrap 255 -> 0
        load(8'd255, 24'h012200); load(8'd0, 24'hF00000);
        go(8'd255);
        check("t4_start_pc", bus.pc, 8'd255);
        run_trace(20);
        check_trace("t4_trace", {9'h101, 9'h0C0});
        check("t4_pc", bus.pc, 8'd0);
        check("t4_halted", bus.halted, 1'b1);

        // write to the fetched address in the fetch cycle: old word issues
        load(8'd0, 24'h031200); load(8'd1, 24'h145600); load(8'd2, 24'hF00000);
        go(8'd0);
        bus.imem_we = 1'b1; bus.imem_waddr = 8'd0; bus.imem_wdata = 24'h0A1200;
        @(negedge clk);
        bus.imem_we = 1'b0;
        check("t5_old_word_func", bus.func, 4'h0);
        check("t5_old_word_rd", bus.rd, 4'h3);
        run_trace(20);
        check_trace("t5_trace", {9'h114, 9'h0C0});

        // rst and start together: rst wins
        rst = 1'b1; bus.start = 1'b1; bus.start_pc = 8'd5;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        check("t6_busy", bus.busy, 1'b0);
        check("t6_pc", bus.pc, 8'd0);
        check("t6_halted", bus.halted, 1'b0);

        // 10-instruction program, rst mid-run, then re-run from 0
        for (int i = 0; i < 10; i++)
            load(8'(i), {4'h0, 4'(i + 1), (i == 3) ? 4'd3 : 4'd0, 4'd0, 8'(i)});
        load(8'd10, 24'hF00000);
        go(8'd0);
        repeat (5) @(negedge clk);
        check("t7_stall_before_rst", bus.stall_cnt, 16'd2);
        check("t7_busy_before_rst", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t7_rst_issue_valid", bus.issue_valid, 1'b0);
        check("t7_rst_pc", bus.pc, 8'd0);
        check("t7_rst_stall", bus.stall_cnt, 16'd0);
        check("t7_rst_busy", bus.busy, 1'b0);
        go(8'd0);
        run_trace(40);
        exp_q = {9'h101, 9'h102, 9'h103, 9'h0C0, 9'h0C0};
        for (int i = 3; i < 10; i++) exp_q.push_back({1'b1, 4'h0, 4'(i + 1)});
        exp_q.push_back(9'h0C0);
        check_trace("t7_trace", exp_q);
        check("t7_stall", bus.stall_cnt, 16'd2);
        check("t7_pc", bus.pc, 8'd10);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
